// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e    : controller FSM states
//   ctrl_t     : bundle of the pipeline control strobes the controller drives
//   CTRL_NOP   : control word with every strobe inactive (no hold, no bubble)
//   REG_ZERO   : architectural x0, which is never a real dependency
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 8;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    IO_WAIT  = 2'd2,
    IO_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic bubble_idex;
    logic flush_ifid;
    logic hold_exmem;
    logic io_req;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline and its hazard controller.
//   Pipeline -> controller : ID source regs and their use flags, EX dest reg and
//                            load/branch flags, EX/MEM IO access flags, io_ready.
//   Controller -> pipeline : stall_pc, stall_ifid, bubble_idex, flush_ifid,
//                            hold_exmem, io_req, io_err.
// master = the controller, slave = the pipeline side.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic [REG_W-1:0] rs1_id;
  logic [REG_W-1:0] rs2_id;
  logic             use_rs1;
  logic             use_rs2;
  logic [REG_W-1:0] rd_ex;
  logic             RegWrite_ex;
  logic             MemRead_ex;
  logic             IoRead_ex;
  logic             branch_taken_ex;
  logic             IoRead_mem;
  logic             IoWrite_mem;
  logic             io_ready;

  logic             stall_pc;
  logic             stall_ifid;
  logic             bubble_idex;
  logic             flush_ifid;
  logic             hold_exmem;
  logic             io_req;
  logic             io_err;

  modport master (
    input  rs1_id, rs2_id, use_rs1, use_rs2, rd_ex, RegWrite_ex, MemRead_ex,
           IoRead_ex, branch_taken_ex, IoRead_mem, IoWrite_mem, io_ready,
    output stall_pc, stall_ifid, bubble_idex, flush_ifid, hold_exmem, io_req,
           io_err
  );

  modport slave (
    output rs1_id, rs2_id, use_rs1, use_rs2, rd_ex, RegWrite_ex, MemRead_ex,
           IoRead_ex, branch_taken_ex, IoRead_mem, IoWrite_mem, io_ready,
    input  stall_pc, stall_ifid, bubble_idex, flush_ifid, hold_exmem, io_req,
           io_err
  );

endinterface

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// Load-use hazard comparator (purely combinational).
//   rs1_id_i, rs2_id_i   : source registers of the instruction in ID
//   use_rs1_i, use_rs2_i : ID instruction actually reads that source
//   rd_ex_i              : destination of the instruction in EX
//   regwrite_ex_i        : EX instruction writes rd
//   memread_ex_i         : EX instruction is a data-memory load
//   ioread_ex_i          : EX instruction is an IO load
//   hazard_o             : ID needs a value the EX load has not produced yet
module pipe_hazard_ctrl_lu_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1_id_i,
  input  logic [REG_W-1:0] rs2_id_i,
  input  logic             use_rs1_i,
  input  logic             use_rs2_i,
  input  logic [REG_W-1:0] rd_ex_i,
  input  logic             regwrite_ex_i,
  input  logic             memread_ex_i,
  input  logic             ioread_ex_i,
  output logic             hazard_o
);

  logic is_load;
  logic rs1_match;
  logic rs2_match;

  assign is_load   = (memread_ex_i | ioread_ex_i) & regwrite_ex_i;
  assign rs1_match = use_rs1_i & (rs1_id_i == rd_ex_i);
  assign rs2_match = use_rs2_i & (rs2_id_i == rd_ex_i);

  // x0 reads as zero regardless of writes, so it never creates a dependency.
  assign hazard_o = is_load & (rd_ex_i != REG_ZERO) & (rs1_match | rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core. Produces the hold/bubble/flush
// strobes for PC, IF/ID, ID/EX and EX/MEM and runs the io_req/io_ready
// handshake for IO accesses parked in EX/MEM.
//   clk   : core clock
//   rst_n : synchronous reset, ACTIVE-HIGH despite its name
//   hz    : pipeline/controller bundle (master side)
// Parameters:
//   LOAD_STALL : bubbles per load-use hazard (1..7)
//   IO_TIMEOUT : max io_req cycles before an IO access is abandoned (1..255)
// All strobes are combinational from state and inputs; only io_err is a
// register output. While reset is asserted every output reads 0.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned IO_TIMEOUT = 255
)
(
  input  logic             clk,
  input  logic             rst_n,
  pipe_hazard_ctrl_if.master hz
);

  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(IO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             io_err_q, io_err_d;
  ctrl_t            ctl;
  logic             hazard_lu;
  logic             io_start;

  pipe_hazard_ctrl_lu_detect u_lu_detect (
    .rs1_id_i      (hz.rs1_id),
    .rs2_id_i      (hz.rs2_id),
    .use_rs1_i     (hz.use_rs1),
    .use_rs2_i     (hz.use_rs2),
    .rd_ex_i       (hz.rd_ex),
    .regwrite_ex_i (hz.RegWrite_ex),
    .memread_ex_i  (hz.MemRead_ex),
    .ioread_ex_i   (hz.IoRead_ex),
    .hazard_o      (hazard_lu)
  );

  assign io_start = hz.IoRead_mem | hz.IoWrite_mem;

  // cnt_q is shared: remaining bubbles in LD_STALL, and in IO_WAIT the number
  // of io_req cycles already spent (the request cycle in RUN counts as one).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    io_err_d = io_err_q;
    ctl      = CTRL_NOP;
    unique case (state_q)
      RUN: begin
        if (io_start) begin
          ctl.io_req     = 1'b1;
          ctl.stall_pc   = 1'b1;
          ctl.stall_ifid = 1'b1;
          ctl.hold_exmem = 1'b1;
          cnt_d          = CNT_ONE;
          if (hz.io_ready) begin
            state_d = IO_DONE;
          end else if (TO_LAST == CNT_ZERO) begin
            io_err_d = 1'b1;
            state_d  = IO_DONE;
          end else begin
            state_d = IO_WAIT;
          end
        end else if (hz.branch_taken_ex) begin
          // The ID instruction is killed, so any load-use it had is moot.
          ctl.flush_ifid  = 1'b1;
          ctl.bubble_idex = 1'b1;
        end else if (hazard_lu) begin
          ctl.stall_pc    = 1'b1;
          ctl.stall_ifid  = 1'b1;
          ctl.bubble_idex = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = LD_STALL;
            cnt_d   = LD_INIT;
          end
        end
      end
      LD_STALL: begin
        ctl.stall_pc    = 1'b1;
        ctl.stall_ifid  = 1'b1;
        ctl.bubble_idex = 1'b1;
        cnt_d           = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = RUN;
        end
      end
      IO_WAIT: begin
        ctl.io_req     = 1'b1;
        ctl.stall_pc   = 1'b1;
        ctl.stall_ifid = 1'b1;
        ctl.hold_exmem = 1'b1;
        cnt_d          = cnt_q + CNT_ONE;
        if (hz.io_ready) begin
          state_d = IO_DONE;
        end else if (cnt_q == TO_LAST) begin
          io_err_d = 1'b1;
          state_d  = IO_DONE;
        end
      end
      IO_DONE: begin
        // One free-running cycle lets EX/MEM advance past the finished
        // access; a branch that resolved in EX meanwhile takes effect now.
        ctl.flush_ifid  = hz.branch_taken_ex;
        ctl.bubble_idex = hz.branch_taken_ex;
        cnt_d           = CNT_ZERO;
        state_d         = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= RUN;
      cnt_q    <= CNT_ZERO;
      io_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      io_err_q <= io_err_d;
    end
  end

  assign hz.stall_pc    = ctl.stall_pc    & ~rst_n;
  assign hz.stall_ifid  = ctl.stall_ifid  & ~rst_n;
  assign hz.bubble_idex = ctl.bubble_idex & ~rst_n;
  assign hz.flush_ifid  = ctl.flush_ifid  & ~rst_n;
  assign hz.hold_exmem  = ctl.hold_exmem  & ~rst_n;
  assign hz.io_req      = ctl.io_req      & ~rst_n;
  assign hz.io_err      = io_err_q        & ~rst_n;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LOAD_STALL=1/IO_TIMEOUT=255 and
// LOAD_STALL=3/IO_TIMEOUT=8) share one stimulus stream. A cycle-level
// reference model tracks remaining stall bubbles, IO request cycles spent and
// the pending release cycle for each instance.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       use_rs1, use_rs2, RegWrite_ex, MemRead_ex, IoRead_ex;
  logic       branch_taken_ex, IoRead_mem, IoWrite_mem, io_ready;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl_if if_a ();
  pipe_hazard_ctrl_if if_b ();

  pipe_hazard_ctrl #(.LOAD_STALL(1), .IO_TIMEOUT(255)) dut_a (
    .clk(clk), .rst_n(rst), .hz(if_a));
  pipe_hazard_ctrl #(.LOAD_STALL(3), .IO_TIMEOUT(8)) dut_b (
    .clk(clk), .rst_n(rst), .hz(if_b));

  always #5 clk = ~clk;

  assign if_a.rs1_id = rs1_id;           assign if_b.rs1_id = rs1_id;
  assign if_a.rs2_id = rs2_id;           assign if_b.rs2_id = rs2_id;
  assign if_a.use_rs1 = use_rs1;         assign if_b.use_rs1 = use_rs1;
  assign if_a.use_rs2 = use_rs2;         assign if_b.use_rs2 = use_rs2;
  assign if_a.rd_ex = rd_ex;             assign if_b.rd_ex = rd_ex;
  assign if_a.RegWrite_ex = RegWrite_ex; assign if_b.RegWrite_ex = RegWrite_ex;
  assign if_a.MemRead_ex = MemRead_ex;   assign if_b.MemRead_ex = MemRead_ex;
  assign if_a.IoRead_ex = IoRead_ex;     assign if_b.IoRead_ex = IoRead_ex;
  assign if_a.branch_taken_ex = branch_taken_ex;
  assign if_b.branch_taken_ex = branch_taken_ex;
  assign if_a.IoRead_mem = IoRead_mem;   assign if_b.IoRead_mem = IoRead_mem;
  assign if_a.IoWrite_mem = IoWrite_mem; assign if_b.IoWrite_mem = IoWrite_mem;
  assign if_a.io_ready = io_ready;       assign if_b.io_ready = io_ready;

  // Observed vector: {stall_pc, stall_ifid, bubble_idex, flush_ifid, hold_exmem, io_req, io_err}
  logic [6:0] obs [2];
  assign obs[0] = {if_a.stall_pc, if_a.stall_ifid, if_a.bubble_idex, if_a.flush_ifid,
                   if_a.hold_exmem, if_a.io_req, if_a.io_err};
  assign obs[1] = {if_b.stall_pc, if_b.stall_ifid, if_b.bubble_idex, if_b.flush_ifid,
                   if_b.hold_exmem, if_b.io_req, if_b.io_err};

  // Reference model state per instance.
  int   LS [2] = '{1, 3};
  int   TO [2] = '{255, 8};
  int   ld_left [2];   // bubbles still owed after the current cycle
  int   io_spent [2];  // io_req cycles already completed for the live access
  bit   io_live [2];
  bit   done [2];      // next cycle is the release cycle after an IO access
  bit   err [2];
  int   n_ld_left [2], n_io_spent [2];
  bit   n_io_live [2], n_done [2], n_err [2];
  logic [6:0] exp_v [2];

  task automatic model_eval();
    bit hz_lu, io_st, sp, si, bb, fl, ho, rq;
    hz_lu = (MemRead_ex | IoRead_ex) & RegWrite_ex & (rd_ex != 5'd0) &
            ((use_rs1 & (rs1_id == rd_ex)) | (use_rs2 & (rs2_id == rd_ex)));
    io_st = IoRead_mem | IoWrite_mem;
    for (int i = 0; i < 2; i++) begin
      sp = 0; si = 0; bb = 0; fl = 0; ho = 0; rq = 0;
      n_ld_left[i] = ld_left[i]; n_io_spent[i] = io_spent[i];
      n_io_live[i] = io_live[i]; n_done[i] = done[i]; n_err[i] = err[i];
      if (rst) begin
        n_ld_left[i] = 0; n_io_spent[i] = 0; n_io_live[i] = 0;
        n_done[i] = 0; n_err[i] = 0;
      end else if (done[i]) begin
        fl = branch_taken_ex; bb = branch_taken_ex; n_done[i] = 0;
      end else if (io_live[i] || (ld_left[i] == 0 && io_st)) begin
        // This cycle is request cycle number io_spent+1 (1 for a fresh start).
        sp = 1; si = 1; ho = 1; rq = 1;
        if (!io_live[i]) n_io_spent[i] = 0;
        if (io_ready) begin
          n_io_live[i] = 0; n_done[i] = 1;
        end else if (n_io_spent[i] + 1 == TO[i]) begin
          n_io_live[i] = 0; n_done[i] = 1; n_err[i] = 1;
        end else begin
          n_io_live[i] = 1; n_io_spent[i] = n_io_spent[i] + 1;
        end
      end else if (ld_left[i] > 0) begin
        sp = 1; si = 1; bb = 1; n_ld_left[i] = ld_left[i] - 1;
      end else if (branch_taken_ex) begin
        fl = 1; bb = 1;
      end else if (hz_lu) begin
        sp = 1; si = 1; bb = 1; n_ld_left[i] = LS[i] - 1;
      end
      exp_v[i] = {sp, si, bb, fl, ho, rq, (rst ? 1'b0 : err[i])};
    end
  endtask

  task automatic clk_step();
    for (int i = 0; i < 2; i++) begin
      ld_left[i] = n_ld_left[i]; io_spent[i] = n_io_spent[i];
      io_live[i] = n_io_live[i]; done[i] = n_done[i]; err[i] = n_err[i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; rs1_id = 0; rs2_id = 0; rd_ex = 0; use_rs1 = 0; use_rs2 = 0;
    RegWrite_ex = 0; MemRead_ex = 0; IoRead_ex = 0; branch_taken_ex = 0;
    IoRead_mem = 0; IoWrite_mem = 0; io_ready = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    #2; model_eval();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 7'b0) begin
        failures++; $display("FAIL reset_active dut%0d: got %b want %b", i, obs[i], 7'b0);
      end
    end
    clk_step();
    rst = 0;
    #2; model_eval();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 7'b0 || obs[i] !== exp_v[i]) begin
        failures++; $display("FAIL reset_idle dut%0d: got %b want %b", i, obs[i], 7'b0);
      end
    end
    clk_step();
  endtask

  task automatic test_load_use();
    clear_inputs();
    for (int c = 0; c < 5; c++) begin
      // lw x5 in EX only on cycle 0; afterwards the bubble occupies EX.
      MemRead_ex = (c == 0); RegWrite_ex = (c == 0); rd_ex = (c == 0) ? 5'd5 : 5'd0;
      use_rs1 = 1; rs1_id = 5'd5;
      #2; model_eval();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          failures++; $display("FAIL load_use_model dut%0d cyc%0d: got %b want %b", i, c, obs[i], exp_v[i]);
        end
      end
      checks++;
      if (if_a.stall_pc !== (c == 0) || if_a.bubble_idex !== (c == 0)) begin
        failures++; $display("FAIL load_use_ls1 cyc%0d: got stall=%b bubble=%b want %b", c, if_a.stall_pc, if_a.bubble_idex, (c == 0));
      end
      checks++;
      if (if_b.stall_pc !== (c < 3) || if_b.stall_ifid !== (c < 3)) begin
        failures++; $display("FAIL load_use_ls3 cyc%0d: got stall=%b want %b", c, if_b.stall_pc, (c < 3));
      end
      clk_step();
    end
    // Load into x0 that ID reads as x0: never a hazard.
    MemRead_ex = 1; RegWrite_ex = 1; rd_ex = 5'd0; use_rs1 = 1; rs1_id = 5'd0;
    for (int c = 0; c < 2; c++) begin
      #2; model_eval();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== 7'b0 || obs[i] !== exp_v[i]) begin
          failures++; $display("FAIL load_use_x0 dut%0d: got %b want %b", i, obs[i], 7'b0);
        end
      end
      clk_step();
    end
    clear_inputs();
  endtask

  task automatic test_io_ready();
    clear_inputs();
    for (int c = 0; c < 7; c++) begin
      IoRead_mem = (c <= 5); io_ready = (c == 4);
      #2; model_eval();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          failures++; $display("FAIL io_ready_model dut%0d cyc%0d: got %b want %b", i, c, obs[i], exp_v[i]);
        end
        checks++;
        if (obs[i] !== ((c <= 4) ? 7'b1100110 : 7'b0)) begin
          failures++; $display("FAIL io_ready_seq dut%0d cyc%0d: got %b want %b", i, c, obs[i], (c <= 4) ? 7'b1100110 : 7'b0);
        end
      end
      clk_step();
    end
    clear_inputs();
  endtask

  task automatic test_branch_priority();
    clear_inputs();
    MemRead_ex = 1; RegWrite_ex = 1; rd_ex = 5'd7; use_rs2 = 1; rs2_id = 5'd7;
    branch_taken_ex = 1;
    #2; model_eval();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 7'b0011000 || obs[i] !== exp_v[i]) begin
        failures++; $display("FAIL branch_over_hazard dut%0d: got %b want %b", i, obs[i], 7'b0011000);
      end
    end
    clk_step();
    clear_inputs();
    #2; model_eval();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 7'b0 || obs[i] !== exp_v[i]) begin
        failures++; $display("FAIL branch_one_cycle dut%0d: got %b want %b", i, obs[i], 7'b0);
      end
    end
    clk_step();
  endtask

  task automatic test_io_timeout();
    clear_inputs();
    for (int c = 0; c < 13; c++) begin
      IoWrite_mem = (c <= 8); io_ready = (c == 8);
      #2; model_eval();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          failures++; $display("FAIL io_timeout_model dut%0d cyc%0d: got %b want %b", i, c, obs[i], exp_v[i]);
        end
      end
      checks++;
      if (if_b.io_req !== (c < 8) || if_b.io_err !== (c >= 8)) begin
        failures++; $display("FAIL io_timeout_b cyc%0d: got req=%b err=%b want req=%b err=%b", c, if_b.io_req, if_b.io_err, (c < 8), (c >= 8));
      end
      checks++;
      if (if_a.io_req !== (c <= 8) || if_a.io_err !== 1'b0) begin
        failures++; $display("FAIL io_timeout_a cyc%0d: got req=%b err=%b want req=%b err=0", c, if_a.io_req, if_a.io_err, (c <= 8));
      end
      clk_step();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_io();
    clear_inputs();
    for (int c = 0; c < 8; c++) begin
      IoRead_mem = (c <= 2);
      rst = (c == 2); io_ready = (c == 2);
      // Cycle 4: load-use hazard proves the controller is back in RUN.
      MemRead_ex = (c == 4); RegWrite_ex = (c == 4); rd_ex = (c == 4) ? 5'd3 : 5'd0;
      use_rs1 = (c == 4); rs1_id = 5'd3;
      #2; model_eval();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          failures++; $display("FAIL reset_mid_io_model dut%0d cyc%0d: got %b want %b", i, c, obs[i], exp_v[i]);
        end
        if (c == 2 || c == 3) begin
          checks++;
          if (obs[i] !== 7'b0) begin
            failures++; $display("FAIL reset_mid_io_zero dut%0d cyc%0d: got %b want %b", i, c, obs[i], 7'b0);
          end
        end
        if (c == 4) begin
          checks++;
          if (obs[i] !== 7'b1110000) begin
            failures++; $display("FAIL reset_mid_io_run dut%0d: got %b want %b", i, obs[i], 7'b1110000);
          end
        end
      end
      clk_step();
    end
    clear_inputs();
  endtask

  task automatic test_random();
    clear_inputs();
    for (int c = 0; c < 600; c++) begin
      rst             = ($urandom_range(0, 63) == 0);
      rs1_id          = 5'($urandom_range(0, 3));
      rs2_id          = 5'($urandom_range(0, 3));
      rd_ex           = 5'($urandom_range(0, 3));
      use_rs1         = 1'($urandom_range(0, 1));
      use_rs2         = 1'($urandom_range(0, 1));
      RegWrite_ex     = ($urandom_range(0, 3) != 0);
      MemRead_ex      = ($urandom_range(0, 2) == 0);
      IoRead_ex       = ($urandom_range(0, 5) == 0);
      branch_taken_ex = ($urandom_range(0, 5) == 0);
      IoRead_mem      = ($urandom_range(0, 9) == 0);
      IoWrite_mem     = ($urandom_range(0, 9) == 0);
      io_ready        = ($urandom_range(0, 3) == 0);
      #2; model_eval();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          failures++; $display("FAIL random dut%0d cyc%0d: got %b want %b", i, c, obs[i], exp_v[i]);
        end
      end
      clk_step();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_io_ready();
    test_branch_priority();
    test_io_timeout();
    test_reset_mid_io();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
